// File: rtl/data_path.sv
// Single-bus 32-bit CPU datapath: registers, PC/IR/MAR/MDR, Y, HI/LO, 64-bit Z and ALU.
// Define DATAPATH_MULDIV_EN to build the signed multiplier and divider.
module data_path #(
  parameter int WIDTH = 32
) (
  input  logic             PCout,
  input  logic             ZHighout,
  input  logic             Zlowout,
  input  logic             MDRout,
  input  logic             R2out,
  input  logic             R3out,
  input  logic             R4out,
  input  logic             R5out,
  input  logic             R6out,
  input  logic             R7out,
  input  logic             MARin,
  input  logic             PCin,
  input  logic             MDRin,
  input  logic             IRin,
  input  logic             Yin,
  input  logic             IncPC,
  input  logic             Read,
  input  logic [4:0]       ADD,
  input  logic             R1in,
  input  logic             R2in,
  input  logic             R3in,
  input  logic             R4in,
  input  logic             R5in,
  input  logic             R6in,
  input  logic             R7in,
  input  logic             R8in,
  input  logic             R9in,
  input  logic             R10in,
  input  logic             R11in,
  input  logic             R12in,
  input  logic             R13in,
  input  logic             R14in,
  input  logic             R15in,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             ZHighIn,
  input  logic             ZLowIn,
  input  logic             Cin,
  input  logic             Clock,
  input  logic             Clear,
  input  logic [WIDTH-1:0] Mdatain
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
`ifdef DATAPATH_MULDIV_EN
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
`endif

  logic [WIDTH-1:0] R1, R2, R3, R4, R5, R6, R7, R8;
  logic [WIDTH-1:0] R9, R10, R11, R12, R13, R14, R15;
  logic [WIDTH-1:0] PC, IR, MAR, MDR, Y, HI, LO;
  logic [2*WIDTH-1:0] Z;
  logic [WIDTH-1:0] BusMuxOut;
  logic [2*WIDTH-1:0] C;

  always_comb begin
    BusMuxOut = '0;
    if (ZHighout)    BusMuxOut = Z[2*WIDTH-1:WIDTH];
    else if (Zlowout) BusMuxOut = Z[WIDTH-1:0];
    else if (PCout)  BusMuxOut = PC;
    else if (MDRout) BusMuxOut = MDR;
    else if (R2out)  BusMuxOut = R2;
    else if (R3out)  BusMuxOut = R3;
    else if (R4out)  BusMuxOut = R4;
    else if (R5out)  BusMuxOut = R5;
    else if (R6out)  BusMuxOut = R6;
    else if (R7out)  BusMuxOut = R7;
  end

  logic [SW-1:0]      sh;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] rol_w, ror_w;

  assign sh    = BusMuxOut[SW-1:0];
  assign sum   = {1'b0, Y} + {1'b0, BusMuxOut} + {{WIDTH{1'b0}}, Cin};
  assign diff  = Y - BusMuxOut - {{(WIDTH-1){1'b0}}, Cin};
  assign rol_w = {Y, Y} << sh;
  assign ror_w = {Y, Y} >> sh;

`ifdef DATAPATH_MULDIV_EN
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem;

  assign prod = {{WIDTH{Y[WIDTH-1]}}, Y} *
                {{WIDTH{BusMuxOut[WIDTH-1]}}, BusMuxOut};
  assign quo  = $signed(Y) / $signed(BusMuxOut);
  assign rem  = $signed(Y) % $signed(BusMuxOut);
`endif

  always_comb begin
    C = '0;
    case (ADD)
      OP_ADD:  C = {{(WIDTH-1){1'b0}}, sum};
      OP_SUB:  C[WIDTH-1:0] = diff;
      OP_AND:  C[WIDTH-1:0] = Y & BusMuxOut;
      OP_OR:   C[WIDTH-1:0] = Y | BusMuxOut;
      OP_SHR:  C[WIDTH-1:0] = Y >> sh;
      OP_SHRA: C[WIDTH-1:0] = $signed(Y) >>> sh;
      OP_SHL:  C[WIDTH-1:0] = Y << sh;
      OP_ROR:  C[WIDTH-1:0] = ror_w[WIDTH-1:0];
      OP_ROL:  C[WIDTH-1:0] = rol_w[2*WIDTH-1:WIDTH];
      OP_NEG:  C[WIDTH-1:0] = -BusMuxOut;
      OP_NOT:  C[WIDTH-1:0] = ~BusMuxOut;
`ifdef DATAPATH_MULDIV_EN
      OP_MUL:  C = prod;
      // Divide by zero returns all-ones quotient and the dividend as remainder
      OP_DIV:  C = (BusMuxOut == '0) ? {Y, {WIDTH{1'b1}}} : {rem, quo};
`endif
      default: C = '0;
    endcase
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      R1  <= '0; R2  <= '0; R3  <= '0; R4  <= '0; R5  <= '0;
      R6  <= '0; R7  <= '0; R8  <= '0; R9  <= '0; R10 <= '0;
      R11 <= '0; R12 <= '0; R13 <= '0; R14 <= '0; R15 <= '0;
      PC  <= '0; IR  <= '0; MAR <= '0; MDR <= '0; Y   <= '0;
      HI  <= '0; LO  <= '0; Z   <= '0;
    end else begin
      if (R1in)  R1  <= BusMuxOut;
      if (R2in)  R2  <= BusMuxOut;
      if (R3in)  R3  <= BusMuxOut;
      if (R4in)  R4  <= BusMuxOut;
      if (R5in)  R5  <= BusMuxOut;
      if (R6in)  R6  <= BusMuxOut;
      if (R7in)  R7  <= BusMuxOut;
      if (R8in)  R8  <= BusMuxOut;
      if (R9in)  R9  <= BusMuxOut;
      if (R10in) R10 <= BusMuxOut;
      if (R11in) R11 <= BusMuxOut;
      if (R12in) R12 <= BusMuxOut;
      if (R13in) R13 <= BusMuxOut;
      if (R14in) R14 <= BusMuxOut;
      if (R15in) R15 <= BusMuxOut;
      if (HIin)  HI  <= BusMuxOut;
      if (LOin)  LO  <= BusMuxOut;
      if (Yin)   Y   <= BusMuxOut;
      if (MARin) MAR <= BusMuxOut;
      if (IRin)  IR  <= BusMuxOut;
      if (MDRin) MDR <= Read ? Mdatain : BusMuxOut;
      if (IncPC)     PC <= PC + 1'b1;
      else if (PCin) PC <= BusMuxOut;
      if (ZLowIn)  Z[WIDTH-1:0]         <= C[WIDTH-1:0];
      if (ZHighIn) Z[2*WIDTH-1:WIDTH]   <= C[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: tb/tb_data_path.sv
// Directed bench for data_path: ALU vector table plus bus/register sequences.
// Expected MUL/DIV results follow DATAPATH_MULDIV_EN.
module tb_data_path;

  logic PCout, ZHighout, Zlowout, MDRout;
  logic R2out, R3out, R4out, R5out, R6out, R7out;
  logic MARin, PCin, MDRin, IRin, Yin, IncPC, Read;
  logic [4:0] ADD;
  logic R1in, R2in, R3in, R4in, R5in, R6in, R7in, R8in;
  logic R9in, R10in, R11in, R12in, R13in, R14in, R15in;
  logic HIin, LOin, ZHighIn, ZLowIn, Cin;
  logic Clock, Clear;
  logic [31:0] Mdatain;

  int n_cmp = 0;
  int n_bad = 0;

  data_path #(.WIDTH(32)) dut (
    .PCout(PCout), .ZHighout(ZHighout), .Zlowout(Zlowout),
    .MDRout(MDRout),
    .R2out(R2out), .R3out(R3out), .R4out(R4out),
    .R5out(R5out), .R6out(R6out), .R7out(R7out),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read),
    .ADD(ADD),
    .R1in(R1in), .R2in(R2in), .R3in(R3in), .R4in(R4in),
    .R5in(R5in), .R6in(R6in), .R7in(R7in), .R8in(R8in),
    .R9in(R9in), .R10in(R10in), .R11in(R11in),
    .R12in(R12in), .R13in(R13in), .R14in(R14in),
    .R15in(R15in),
    .HIin(HIin), .LOin(LOin),
    .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .Cin(Cin),
    .Clock(Clock), .Clear(Clear), .Mdatain(Mdatain)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [63:0] exp;
  } vec_t;

  vec_t vt[20];

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic idle();
    PCout = 0; ZHighout = 0; Zlowout = 0; MDRout = 0;
    R2out = 0; R3out = 0; R4out = 0; R5out = 0;
    R6out = 0; R7out = 0;
    MARin = 0; PCin = 0; MDRin = 0; IRin = 0; Yin = 0;
    IncPC = 0; Read = 0; ADD = 5'b0;
    R1in = 0; R2in = 0; R3in = 0; R4in = 0; R5in = 0;
    R6in = 0; R7in = 0; R8in = 0; R9in = 0; R10in = 0;
    R11in = 0; R12in = 0; R13in = 0; R14in = 0; R15in = 0;
    HIin = 0; LOin = 0; ZHighIn = 0; ZLowIn = 0; Cin = 0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic mem_to_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1; MDRin = 1;
    tick();
  endtask

  task automatic load_y(input logic [31:0] v);
    mem_to_mdr(v);
    MDRout = 1; Yin = 1;
    tick();
  endtask

  task automatic alu(input logic [4:0] op, input logic [31:0] b,
                     input logic c, input logic hi, input logic lo);
    mem_to_mdr(b);
    MDRout = 1; ADD = op; Cin = c;
    ZHighIn = hi; ZLowIn = lo;
    tick();
  endtask

  initial begin
    vt[0]  = '{5'b00011, 32'h12, 32'h14, 1'b0, 64'h26};
    vt[1]  = '{5'b00011, 32'hFFFFFFFF, 32'h1, 1'b0, 64'h1_00000000};
    vt[2]  = '{5'b00011, 32'hFFFFFFFF, 32'h0, 1'b1, 64'h1_00000000};
    vt[3]  = '{5'b00100, 32'h14, 32'h12, 1'b0, 64'h2};
    vt[4]  = '{5'b00100, 32'h12, 32'h14, 1'b1, 64'hFFFFFFFD};
    vt[5]  = '{5'b00101, 32'hF0F0, 32'hFF00, 1'b0, 64'hF000};
    vt[6]  = '{5'b00110, 32'hF0F0, 32'h0F00, 1'b0, 64'hFFF0};
    vt[7]  = '{5'b00111, 32'h80000000, 32'h4, 1'b0, 64'h08000000};
    vt[8]  = '{5'b01000, 32'h80000000, 32'h4, 1'b0, 64'hF8000000};
    vt[9]  = '{5'b01001, 32'h1, 32'h24, 1'b0, 64'h10};
    vt[10] = '{5'b01010, 32'h1, 32'h1, 1'b0, 64'h80000000};
    vt[11] = '{5'b01011, 32'h80000000, 32'h4, 1'b0, 64'h8};
    vt[12] = '{5'b01011, 32'h12345678, 32'h20, 1'b0, 64'h12345678};
    vt[13] = '{5'b10001, 32'h5, 32'h1, 1'b0, 64'hFFFFFFFF};
    vt[14] = '{5'b10010, 32'h5, 32'h0F0F0F0F, 1'b0, 64'hF0F0F0F0};
    vt[15] = '{5'b00000, 32'h5, 32'h3, 1'b0, 64'h0};
`ifdef DATAPATH_MULDIV_EN
    vt[16] = '{5'b01111, 32'h12, 32'h14, 1'b0, 64'h168};
    vt[17] = '{5'b01111, 32'hFFFFFFFE, 32'h3, 1'b0,
               64'hFFFFFFFF_FFFFFFFA};
    vt[18] = '{5'b10000, 32'h80000000, 32'h0, 1'b0,
               64'h80000000_FFFFFFFF};
    vt[19] = '{5'b10000, 32'd100, 32'd7, 1'b0, 64'h2_0000000E};
`else
    vt[16] = '{5'b01111, 32'h12, 32'h14, 1'b0, 64'h0};
    vt[17] = '{5'b01111, 32'hFFFFFFFE, 32'h3, 1'b0, 64'h0};
    vt[18] = '{5'b10000, 32'h80000000, 32'h0, 1'b0, 64'h0};
    vt[19] = '{5'b10000, 32'd100, 32'd7, 1'b0, 64'h0};
`endif

    idle();
    Mdatain = 32'h0;
    Clear = 1'b1;
    #12;
    check("reset_R1", {32'h0, dut.R1}, 64'h0);
    check("reset_PC", {32'h0, dut.PC}, 64'h0);
    check("reset_Z", dut.Z, 64'h0);
    check("reset_bus", {32'h0, dut.BusMuxOut}, 64'h0);
    Clear = 1'b0;
    #1;

    mem_to_mdr(32'h12);
    MDRout = 1; R2in = 1; tick();
    check("R2_load", {32'h0, dut.R2}, 64'h12);
    mem_to_mdr(32'h14);
    MDRout = 1; R3in = 1; tick();
    check("R3_load", {32'h0, dut.R3}, 64'h14);

    R2out = 1; Yin = 1; tick();
    R3out = 1; ADD = 5'b00011; ZLowIn = 1; tick();
    check("add_Z", dut.Z, 64'h26);
    Zlowout = 1; R1in = 1; tick();
    check("add_R1", {32'h0, dut.R1}, 64'h26);
    R3out = 1; ADD = 5'b00011; Cin = 1; ZLowIn = 1; tick();
    Zlowout = 1; R1in = 1; tick();
    check("addc_R1", {32'h0, dut.R1}, 64'h27);

    PCout = 1; MARin = 1; IncPC = 1; tick();
    check("fetch_MAR", {32'h0, dut.MAR}, 64'h0);
    check("fetch_PC", {32'h0, dut.PC}, 64'h1);
    mem_to_mdr(32'h28918000);
    MDRout = 1; IRin = 1; tick();
    check("fetch_IR", {32'h0, dut.IR}, 64'h28918000);

    // Drive and reload MDR in the same cycle: bus carries the old value
    Mdatain = 32'hAAAA; Read = 1; MDRin = 1;
    MDRout = 1; R4in = 1; tick();
    check("same_R4", {32'h0, dut.R4}, 64'h28918000);
    check("same_MDR", {32'h0, dut.MDR}, 64'hAAAA);

    R2out = 1; PCin = 1; IncPC = 1; tick();
    check("incpc_prio", {32'h0, dut.PC}, 64'h2);
    R3out = 1; PCin = 1; tick();
    check("pcin_bus", {32'h0, dut.PC}, 64'h14);

    R3out = 1; HIin = 1; tick();
    R2out = 1; LOin = 1; tick();
    check("HI", {32'h0, dut.HI}, 64'h14);
    check("LO", {32'h0, dut.LO}, 64'h12);
    R3out = 1; R5in = 1; R15in = 1; tick();
    check("R15", {32'h0, dut.R15}, 64'h14);

    for (int i = 0; i < 20; i++) begin
      load_y(vt[i].a);
      alu(vt[i].op, vt[i].b, vt[i].cin, 1'b1, 1'b1);
      check($sformatf("alu[%0d] op=%b", i, vt[i].op), dut.Z, vt[i].exp);
    end

    // Bus priority, peeling one source off at a time
    ZHighout = 1; Zlowout = 1; PCout = 1; MDRout = 1; R2out = 1; #1;
    check("bus_zhigh", {32'h0, dut.BusMuxOut}, {32'h0, vt[19].exp[63:32]});
    ZHighout = 0; #1;
    check("bus_zlow", {32'h0, dut.BusMuxOut}, {32'h0, vt[19].exp[31:0]});
    Zlowout = 0; #1;
    check("bus_pc", {32'h0, dut.BusMuxOut}, 64'h14);
    PCout = 0; #1;
    check("bus_mdr", {32'h0, dut.BusMuxOut}, 64'h7);
    MDRout = 0; R7out = 1; #1;
    check("bus_r2", {32'h0, dut.BusMuxOut}, 64'h12);
    R2out = 0; R7out = 0; R5out = 1; #1;
    check("bus_r5", {32'h0, dut.BusMuxOut}, 64'h14);
    idle(); #1;

    Clear = 1'b1; #2;
    check("clr_R1", {32'h0, dut.R1}, 64'h0);
    check("clr_R2", {32'h0, dut.R2}, 64'h0);
    check("clr_R15", {32'h0, dut.R15}, 64'h0);
    check("clr_PC", {32'h0, dut.PC}, 64'h0);
    check("clr_IR", {32'h0, dut.IR}, 64'h0);
    check("clr_MDR", {32'h0, dut.MDR}, 64'h0);
    check("clr_Y", {32'h0, dut.Y}, 64'h0);
    check("clr_HILO", {dut.HI, dut.LO}, 64'h0);
    check("clr_Z", dut.Z, 64'h0);
    check("clr_bus", {32'h0, dut.BusMuxOut}, 64'h0);
    Clear = 1'b0;
    #1;

    load_y(32'hFFFFFFFF);
    alu(5'b00011, 32'h1, 1'b0, 1'b1, 1'b0);
    check("zhigh_only", dut.Z, 64'h1_00000000);
    alu(5'b00101, 32'hFFFF, 1'b0, 1'b0, 1'b1);
    check("zlow_only", dut.Z, 64'h1_0000FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
